// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz round controller.
// Slice helpers take wide zero-extended buses so any pad width fits.
package quiz_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REL,
        S_ARMED,
        S_LOCKOUT,
        S_DONE
    } state_t;

    localparam int LOCK_CNT_W = 8;
    localparam int MAX_ANS_W  = 32;
    localparam int MAX_BUS_W  = 256;

    function automatic logic is_onehot(input logic [MAX_ANS_W-1:0] v);
        return $onehot(v);
    endfunction

    function automatic logic [MAX_ANS_W-1:0] pad_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   p,
        input int                   w
    );
        logic [MAX_BUS_W-1:0] sh;
        logic [MAX_ANS_W-1:0] r;
        sh = bus >> (p * w);
        r  = '0;
        for (int i = 0; i < MAX_ANS_W; i++) begin
            if (i < w) r[i] = sh[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/score_sat.sv
// One per-player saturating score counter.
module score_sat #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] score
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (clr) begin
            score <= '0;
        end else if (inc && score != '1) begin
            score <= score + 1'b1;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round controller: arbitrates answer pads, scores, lockout and question step.
// All outputs are registered; scores live in the score_sat instances.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_Q       = 9,
    parameter int ANS_W       = 9,
    parameter int SCORE_W     = 4,
    parameter int LOCK_CYCLES = 8,
    parameter int QI_W        = $clog2(NUM_Q),
    parameter int WIN_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           bank_sel,
    input  logic [NUM_PLAYERS*ANS_W-1:0]   pad_in,
    input  logic [ANS_W-1:0]               key,
    output logic                           bank_q,
    output logic [QI_W-1:0]                q_idx,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [WIN_W-1:0]               winner,
    output logic                           point_pulse,
    output logic                           skip_pulse,
    output logic [NUM_PLAYERS-1:0]         locked,
    output logic                           round_done,
    output logic                           busy
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LOAD = LOCK_CNT_W'(LOCK_CYCLES - 1);

    state_t                  state;
    logic [LOCK_CNT_W-1:0]   lock_cnt;
    logic [NUM_PLAYERS-1:0]  hit;
    logic [NUM_PLAYERS-1:0]  miss;
    logic [WIN_W-1:0]        win_idx;
    logic [ANS_W-1:0]        slice;
    logic                    start_ok;
    logic                    armed;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign armed    = (state == S_ARMED);

    // Walk high to low so the lowest-index correct player ends up in win_idx.
    always_comb begin
        hit     = '0;
        miss    = '0;
        win_idx = '0;
        slice   = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            slice = ANS_W'(pad_slice(MAX_BUS_W'(pad_in), p, ANS_W));
            if (!locked[p] && is_onehot(MAX_ANS_W'(slice))) begin
                hit[p]  = (slice == key);
                miss[p] = (slice != key);
                if (slice == key) win_idx = WIN_W'(p);
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
        score_sat #(
            .W(SCORE_W)
        ) u_score (
            .clk  (clk),
            .rst  (rst),
            .clr  (start_ok),
            .inc  (armed && hit[p] && win_idx == WIN_W'(p)),
            .score(scores[p*SCORE_W +: SCORE_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            lock_cnt    <= '0;
            bank_q      <= 1'b0;
            q_idx       <= '0;
            winner      <= '0;
            point_pulse <= 1'b0;
            skip_pulse  <= 1'b0;
            locked      <= '0;
            round_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            point_pulse <= 1'b0;
            skip_pulse  <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        q_idx      <= '0;
                        locked     <= '0;
                        bank_q     <= bank_sel;
                        round_done <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_WAIT_REL;
                    end
                end
                S_WAIT_REL: begin
                    if (pad_in == '0) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (|hit) begin
                        winner      <= win_idx;
                        point_pulse <= 1'b1;
                        lock_cnt    <= LOCK_LOAD;
                        state       <= S_LOCKOUT;
                    end else if (|miss) begin
                        locked <= locked | miss;
                        if (&(locked | miss)) begin
                            skip_pulse <= 1'b1;
                            lock_cnt   <= LOCK_LOAD;
                            state      <= S_LOCKOUT;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (lock_cnt != '0) begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end else if (q_idx == QI_W'(NUM_Q - 1)) begin
                        round_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        q_idx  <= q_idx + 1'b1;
                        locked <= '0;
                        state  <= S_WAIT_REL;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl with a question-level reference model.
module tb_quiz_round_ctrl;

    localparam int NP = 2;
    localparam int AW = 9;
    localparam int SW = 3;
    localparam int NQ = 9;
    localparam int L  = 8;
    localparam int QW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           bank_sel = 1'b0;
    logic [17:0]    pad_in = '0;
    logic [8:0]     key;
    logic           bank_q;
    logic [QW-1:0]  q_idx;
    logic [5:0]     scores;
    logic [0:0]     winner;
    logic           point_pulse;
    logic           skip_pulse;
    logic [1:0]     locked;
    logic           round_done;
    logic           busy;

    logic [8:0] rom [2][16];

    int checks = 0;
    int failures = 0;

    int       m_score [2];
    bit [1:0] m_locked;
    int       m_q;
    bit       m_bank;
    int       m_winner;

    assign key = rom[bank_q][q_idx];

    always #5 clk = ~clk;

    quiz_round_ctrl #(
        .NUM_PLAYERS(NP),
        .NUM_Q      (NQ),
        .ANS_W      (AW),
        .SCORE_W    (SW),
        .LOCK_CYCLES(L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bank_sel   (bank_sel),
        .pad_in     (pad_in),
        .key        (key),
        .bank_q     (bank_q),
        .q_idx      (q_idx),
        .scores     (scores),
        .winner     (winner),
        .point_pulse(point_pulse),
        .skip_pulse (skip_pulse),
        .locked     (locked),
        .round_done (round_done),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] exp_scores();
        return {3'(m_score[1]), 3'(m_score[0])};
    endfunction

    function automatic void model_reset();
        m_score  = '{0, 0};
        m_locked = '0;
        m_q      = 0;
        m_bank   = 0;
        m_winner = 0;
    endfunction

    function automatic logic [8:0] onehot9(input int b);
        logic [8:0] one;
        one = 9'd1;
        return one << b;
    endfunction

    function automatic logic [8:0] rnd_slice(input logic [8:0] k);
        int a;
        int b;
        case ($urandom_range(0, 4))
            0: return '0;
            1: return k;
            2: return onehot9($urandom_range(0, 8));
            3: begin
                a = $urandom_range(0, 8);
                b = (a + 1 + $urandom_range(0, 7)) % 9;
                return onehot9(a) | onehot9(b);
            end
            default: return '0;
        endcase
    endfunction

    // One ARMED cycle: model judges the pads from the game rules, DUT is compared.
    task automatic answer(input logic [17:0] pads, output int kind);
        logic [8:0]  k;
        logic [8:0]  s;
        logic [10:0] exp_v;
        logic [10:0] obs_v;
        bit [1:0]    wr;
        int          w;
        k    = rom[m_bank][m_q];
        kind = 0;
        w    = -1;
        wr   = '0;
        for (int p = 0; p < NP; p++) begin
            if (!m_locked[p]) begin
                s = pads[p*AW +: AW];
                if ($countones(s) == 1) begin
                    if (s == k) begin
                        if (w < 0) w = p;
                    end else begin
                        wr[p] = 1'b1;
                    end
                end
            end
        end
        if (w >= 0) begin
            kind     = 1;
            m_winner = w;
            if (m_score[w] < 7) m_score[w]++;
        end else begin
            m_locked = m_locked | wr;
            if (m_locked == 2'b11) kind = 2;
        end
        pad_in = pads;
        tick();
        exp_v = {kind == 1, kind == 2, 1'(m_winner), exp_scores(), m_locked};
        obs_v = {point_pulse, skip_pulse, winner, scores, locked};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL answer q=%0d pads=%h got=%b exp=%b", m_q, pads, obs_v, exp_v);
        end
    endtask

    task automatic lockout(input logic [17:0] hold);
        pad_in = hold;
        for (int i = 0; i < L - 1; i++) begin
            tick();
            checks++;
            if ({q_idx, point_pulse, skip_pulse, round_done, busy, scores} !==
                {4'(m_q), 4'b0001, exp_scores()}) begin
                failures++;
                $display("FAIL lockout_hold i=%0d q_idx=%0d exp=%0d pp=%b sp=%b",
                         i, q_idx, m_q, point_pulse, skip_pulse);
            end
        end
        tick();
        checks++;
        if (m_q == NQ - 1) begin
            if ({q_idx, round_done, busy} !== {4'(m_q), 2'b10}) begin
                failures++;
                $display("FAIL lockout_done q_idx=%0d done=%b busy=%b exp q=%0d done=1 busy=0",
                         q_idx, round_done, busy, m_q);
            end
        end else begin
            m_q++;
            m_locked = '0;
            if ({q_idx, locked, round_done, busy} !== {4'(m_q), 4'b0001}) begin
                failures++;
                $display("FAIL lockout_next q_idx=%0d locked=%b exp q=%0d locked=00",
                         q_idx, locked, m_q);
            end
        end
    endtask

    task automatic release_pads(input logic [17:0] hold, input int n);
        pad_in = hold;
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if ({point_pulse, skip_pulse, scores} !== {2'b00, exp_scores()}) begin
                failures++;
                $display("FAIL held_pad pp=%b sp=%b scores=%h exp=%h",
                         point_pulse, skip_pulse, scores, exp_scores());
            end
        end
        pad_in = '0;
        tick();
    endtask

    task automatic do_start(input bit b);
        start    = 1'b1;
        bank_sel = b;
        pad_in   = '0;
        tick();
        start    = 1'b0;
        m_bank   = b;
        m_q      = 0;
        m_score  = '{0, 0};
        m_locked = '0;
        checks++;
        if ({busy, round_done, bank_q, q_idx, scores, locked} !==
            {2'b10, b, 4'd0, 6'd0, 2'b00}) begin
            failures++;
            $display("FAIL start busy=%b done=%b bank_q=%b q=%0d scores=%h locked=%b",
                     busy, round_done, bank_q, q_idx, scores, locked);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bank_q, q_idx, scores, winner, point_pulse, skip_pulse, locked, round_done, busy} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0",
                     {bank_q, q_idx, scores, winner, point_pulse, skip_pulse, locked, round_done, busy});
        end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_start_point();
        int kind;
        do_start(1'b1);
        answer({rom[1][0], 9'd0}, kind);
        lockout('0);
        release_pads('0, 0);
    endtask

    task automatic test_tie();
        int kind;
        answer({rom[1][1], rom[1][1]}, kind);
        lockout('0);
        release_pads('0, 0);
    endtask

    task automatic test_lock_skip();
        int kind;
        logic [8:0] k;
        logic [8:0] w;
        k = rom[1][2];
        w = {k[7:0], k[8]};
        answer({9'd0, w}, kind);
        answer({w, k}, kind);
        lockout('0);
        release_pads('0, 0);
    endtask

    task automatic test_held_pad();
        int kind;
        answer({9'd0, rom[1][3]}, kind);
        lockout({9'd0, rom[1][4]});
        release_pads({9'd0, rom[1][4]}, 3);
        start    = 1'b1;
        bank_sel = 1'b0;
        tick();
        start    = 1'b0;
        checks++;
        if ({bank_q, q_idx, busy, scores} !== {1'b1, 4'(m_q), 1'b1, exp_scores()}) begin
            failures++;
            $display("FAIL start_ignored bank_q=%b q=%0d busy=%b scores=%h",
                     bank_q, q_idx, busy, scores);
        end
        answer({9'd0, 9'b000001100}, kind);
        answer({rom[1][4], 9'd0}, kind);
        lockout('0);
        release_pads('0, 0);
    endtask

    task automatic play_random_round();
        int          kind;
        int          tries;
        bit          done;
        logic [8:0]  k;
        logic [17:0] pads;
        done = 0;
        while (!done) begin
            kind  = 0;
            tries = 0;
            while (kind == 0 && tries < 12) begin
                k    = rom[m_bank][m_q];
                pads = {rnd_slice(k), rnd_slice(k)};
                answer(pads, kind);
                tries++;
            end
            if (kind == 0) begin
                k = rom[m_bank][m_q];
                pads = m_locked[0] ? {k, 9'd0} : {9'd0, k};
                answer(pads, kind);
            end
            pads = {rnd_slice(k), rnd_slice(k)};
            if (m_q == NQ - 1) begin
                lockout(pads);
                done = 1;
            end else begin
                lockout(pads);
                release_pads(pads, $urandom_range(0, 2));
            end
        end
    endtask

    task automatic test_random();
        play_random_round();
        do_start(1'($urandom_range(0, 1)));
        play_random_round();
    endtask

    task automatic test_saturation();
        int kind;
        do_start(1'b0);
        for (int q = 0; q < NQ; q++) begin
            answer({9'd0, rom[0][q]}, kind);
            lockout('0);
            if (q < NQ - 1) release_pads('0, 0);
        end
        checks++;
        if (scores[2:0] !== 3'd7) begin
            failures++;
            $display("FAIL saturate score0=%0d exp=7", scores[2:0]);
        end
    endtask

    task automatic test_async_reset();
        int kind;
        do_start(1'b1);
        answer({rom[1][0], 9'd0}, kind);
        pad_in = '0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bank_q, q_idx, scores, winner, point_pulse, skip_pulse, locked, round_done, busy} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0",
                     {bank_q, q_idx, scores, winner, point_pulse, skip_pulse, locked, round_done, busy});
        end
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if ({busy, round_done, q_idx} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b done=%b q=%0d", busy, round_done, q_idx);
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int q = 0; q < 16; q++) begin
                rom[b][q] = onehot9($urandom_range(0, 8));
            end
        end
        rom[1][0] = 9'b000001000;
        model_reset();
        test_reset();
        test_start_point();
        test_tie();
        test_lock_skip();
        test_held_pad();
        test_random();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
